// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer (grant, access, response) in front of data_memory.
// Optional DMEM_ARB_ALIGN_CHECK_EN makes misaligned halfword/word accesses illegal.
module dmem_arbiter #(
    parameter int DEPTH = 400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [2:0]  i_mode0,
    input  logic [2:0]  i_mode1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_rvalid0,
    output logic        o_rvalid1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic        o_err0,
    output logic        o_err1,
    output logic        o_mem_rd_en,
    output logic        o_mem_wr_en,
    output logic [31:0] o_mem_addr,
    output logic [2:0]  o_mem_acc_mode,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);
    localparam logic [1:0] S_IDLE = 2'd0, S_ACCESS = 2'd1, S_RESP = 2'd2;
    logic [1:0]  r_state;
    logic        r_ptr, r_port, r_we;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [2:0]  r_mode;
    logic        w_idle, w_access, w_resp, w_gnt0, w_gnt1;
    logic [2:0]  w_size;
    logic [32:0] w_end;
    logic        w_mode_bad, w_range_bad, w_align_bad, w_err;
    assign w_idle   = r_state == S_IDLE;
    assign w_access = r_state == S_ACCESS;
    assign w_resp   = r_state == S_RESP;
    // rst_n gating keeps grants low while reset holds the FSM in IDLE
    assign w_gnt0 = rst_n && w_idle && i_req0 && (!i_req1 || !r_ptr);
    assign w_gnt1 = rst_n && w_idle && i_req1 && (!i_req0 || r_ptr);
    assign o_gnt0 = w_gnt0;
    assign o_gnt1 = w_gnt1;
    assign w_size = (r_mode[1:0] == 2'b10) ? 3'd4 : r_mode[0] ? 3'd2 : 3'd1;
    assign w_end  = {1'b0, r_addr} + {30'd0, w_size};
    assign w_mode_bad  = (r_mode == 3'b011) || (r_mode[2:1] == 2'b11) || (r_we && r_mode[2]);
    assign w_range_bad = w_end > 33'(DEPTH);
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign w_align_bad = ((r_mode[1:0] == 2'b01) && r_addr[0]) || ((r_mode == 3'b010) && (r_addr[1:0] != 2'b00));
`else
    assign w_align_bad = 1'b0;
`endif
    assign w_err = w_mode_bad || w_range_bad || w_align_bad;
    assign o_mem_rd_en    = w_access && !w_err && !r_we;
    assign o_mem_wr_en    = w_access && !w_err && r_we;
    assign o_mem_addr     = w_access ? r_addr : '0;
    assign o_mem_acc_mode = w_access ? r_mode : '0;
    assign o_mem_wdata    = w_access ? r_wdata : '0;
    assign o_rvalid0 = w_resp && !r_port;
    assign o_rvalid1 = w_resp && r_port;
    assign o_err0    = o_rvalid0 && w_err;
    assign o_err1    = o_rvalid1 && w_err;
    assign o_rdata0  = o_rvalid0 ? r_rdata : '0;
    assign o_rdata1  = o_rvalid1 ? r_rdata : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 1'b0;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_mode  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_gnt0 || w_gnt1) begin
                    r_state <= S_ACCESS;
                    r_ptr   <= w_gnt0;
                    r_port  <= w_gnt1;
                    r_we    <= w_gnt1 ? i_we1 : i_we0;
                    r_addr  <= w_gnt1 ? i_addr1 : i_addr0;
                    r_mode  <= w_gnt1 ? i_mode1 : i_mode0;
                    r_wdata <= w_gnt1 ? i_wdata1 : i_wdata0;
                end
                S_ACCESS: begin
                    r_state <= S_RESP;
                    r_rdata <= o_mem_rd_en ? i_mem_rdata : '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
